// File: rtl/flappy_pkg.sv
// Shared types and defaults for the Flappy Bird game controller.
package flappy_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } game_state_t;

  localparam int ROWS_DEF      = 8;
  localparam int SCORE_MAX_DEF = 99;
  localparam int SCORE_W       = 7;

endpackage

// File: rtl/flappy_game_ctrl_if.sv
// Signal bundle between the game controller and the key / bird / pipe / display side.
interface flappy_game_ctrl_if #(
  parameter int ROWS = 8
);

  logic            start;
  logic [ROWS-1:0] bird_col;
  logic [ROWS-1:0] pipe_col;
  logic            pipe_pass;
  logic            active;
  logic            gameover;
  logic            tick;
  logic            pipe_tick;
  logic [6:0]      score;
  logic [1:0]      state;

  // Game side: drives keys and column status, observes controls.
  modport master (
    output start, bird_col, pipe_col, pipe_pass,
    input  active, gameover, tick, pipe_tick, score, state
  );

  // Controller side.
  modport slave (
    input  start, bird_col, pipe_col, pipe_pass,
    output active, gameover, tick, pipe_tick, score, state
  );

endinterface

// File: rtl/tick_divider.sv
// Modulo-N counter; hit is a combinational terminal-count pulse for the enable
// event that wraps the count. The caller registers it.
module tick_divider #(
  parameter int N = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic hit
);

  localparam int           W    = (N > 1) ? $clog2(N) : 1;
  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] cnt;

  assign hit = en && !clr && (cnt == LAST);

  // Count enabled events, wrapping at N; clear dominates enable.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/flappy_game_ctrl.sv
// Flappy Bird sequencer: game FSM, bird/pipe tick generation, collision detect, score.
module flappy_game_ctrl
  import flappy_pkg::*;
#(
  parameter int ROWS       = ROWS_DEF,
  parameter int TICK_DIV   = 64,
  parameter int PIPE_TICKS = 4,
  parameter int SCORE_MAX  = SCORE_MAX_DEF
) (
  input logic               clk,
  input logic               reset,
  flappy_game_ctrl_if.slave bus
);

  localparam logic [SCORE_W-1:0] SCORE_LIM = SCORE_W'(SCORE_MAX);

  game_state_t      state_q, state_d;
  logic             active_q, active_d;
  logic             gameover_q, gameover_d;
  logic             tick_q, pipe_tick_q;
  logic [SCORE_W-1:0] score_q;
  logic [ROWS-1:0]  overlap;
  logic             coll;
  logic             div_en, div_clr;
  logic             bird_hit, pipe_hit;

  assign overlap = bus.bird_col & bus.pipe_col;
  assign coll    = (state_q == PLAY) && ((overlap != '0) || (bus.bird_col == '0));

  // Divider runs only while the game stays in PLAY; entering PLAY counts as the
  // first step, so the first tick lands TICK_DIV cycles after entry. Any exit
  // (collision, reset) clears both counters so no tick follows a collision.
  assign div_en  = (state_d == PLAY);
  assign div_clr = (state_d != PLAY);

  tick_divider #(.N(TICK_DIV)) u_bird_div (
    .clk   (clk),
    .reset (reset),
    .en    (div_en),
    .clr   (div_clr),
    .hit   (bird_hit)
  );

  tick_divider #(.N(PIPE_TICKS)) u_pipe_div (
    .clk   (clk),
    .reset (reset),
    .en    (bird_hit),
    .clr   (div_clr),
    .hit   (pipe_hit)
  );

  // Next-state and registered-output decode for the game FSM.
  always_comb begin
    state_d    = state_q;
    active_d   = 1'b0;
    gameover_d = 1'b0;
    case (state_q)
      IDLE:    if (bus.start) state_d = PLAY;
      PLAY:    if (coll)      state_d = OVER;
      OVER:    if (bus.start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    active_d   = (state_d != IDLE);
    gameover_d = (state_d == OVER);
  end

  // FSM state and control output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      active_q    <= 1'b0;
      gameover_q  <= 1'b0;
      tick_q      <= 1'b0;
      pipe_tick_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      active_q    <= active_d;
      gameover_q  <= gameover_d;
      tick_q      <= bird_hit;
      pipe_tick_q <= pipe_hit;
    end
  end

  // Score: clears on game start, saturating count of clean pipe passes in PLAY.
  always_ff @(posedge clk) begin
    if (reset) begin
      score_q <= '0;
    end else if ((state_q == IDLE) && bus.start) begin
      score_q <= '0;
    end else if ((state_q == PLAY) && bus.pipe_pass && !coll && (score_q < SCORE_LIM)) begin
      score_q <= score_q + SCORE_W'(1);
    end
  end

  assign bus.active    = active_q;
  assign bus.gameover  = gameover_q;
  assign bus.tick      = tick_q;
  assign bus.pipe_tick = pipe_tick_q;
  assign bus.score     = score_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_flappy_game_ctrl.sv
// Directed bench for flappy_game_ctrl with TICK_DIV=4, PIPE_TICKS=3.
module tb_flappy_game_ctrl;

  localparam int ROWS = 8;
  localparam int TD   = 4;
  localparam int PT   = 3;
  localparam int SM   = 99;

  logic clk = 1'b0;
  logic reset;
  int   passed = 0;
  int   total  = 0;

  flappy_game_ctrl_if #(.ROWS(ROWS)) bus ();

  flappy_game_ctrl #(
    .ROWS       (ROWS),
    .TICK_DIV   (TD),
    .PIPE_TICKS (PT),
    .SCORE_MAX  (SM)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic go_idle_then_play();
    bus.start = 1'b1; step(); bus.start = 1'b0;
    bus.start = 1'b1; step(); bus.start = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.bird_col  = 8'h10;
    bus.pipe_col  = 8'h00;
    bus.pipe_pass = 1'b0;
    step(); step();

    // Reset state
    chk("rst_state",    32'(bus.state),     0);
    chk("rst_active",   32'(bus.active),    0);
    chk("rst_gameover", 32'(bus.gameover),  0);
    chk("rst_score",    32'(bus.score),     0);
    chk("rst_tick",     32'(bus.tick),      0);
    chk("rst_ptick",    32'(bus.pipe_tick), 0);

    reset = 1'b0;
    step();
    chk("idle_hold", 32'(bus.state), 0);

    // Start -> PLAY, this is PLAY cycle 1
    bus.start = 1'b1; step(); bus.start = 1'b0;
    chk("start_active",   32'(bus.active),   1);
    chk("start_state",    32'(bus.state),    1);
    chk("start_gameover", 32'(bus.gameover), 0);

    // Tick at cycles 4,8,12,...; pipe_tick at 12 and 24
    for (int c = 1; c <= 30; c++) begin
      chk("tick_cad",  32'(bus.tick),      (c % 4  == 0) ? 1 : 0);
      chk("ptick_cad", 32'(bus.pipe_tick), (c % 12 == 0) ? 1 : 0);
      step();
    end

    // Scoring: five clean pipe passes
    bus.pipe_pass = 1'b1; step(); bus.pipe_pass = 1'b0;
    chk("score_1", 32'(bus.score), 1);
    step();
    for (int k = 0; k < 4; k++) begin
      bus.pipe_pass = 1'b1; step(); bus.pipe_pass = 1'b0; step();
    end
    chk("score_5", 32'(bus.score), 5);

    // start has no effect in PLAY
    bus.start = 1'b1; step(); bus.start = 1'b0;
    chk("play_start_ign", 32'(bus.state), 1);
    chk("play_start_scr", 32'(bus.score), 5);

    // Overlap collision coincident with pipe_pass
    bus.pipe_col = 8'h30; bus.pipe_pass = 1'b1;
    step();
    bus.pipe_col = 8'h00; bus.pipe_pass = 1'b0;
    chk("coll_gameover", 32'(bus.gameover), 1);
    chk("coll_state",    32'(bus.state),    2);
    chk("coll_active",   32'(bus.active),   1);
    chk("coll_score",    32'(bus.score),    5);
    chk("coll_tick",     32'(bus.tick),     0);
    for (int k = 0; k < 8; k++) begin
      step();
      chk("over_tick",  32'(bus.tick),  0);
      chk("over_state", 32'(bus.state), 2);
    end

    // Restart: OVER -> IDLE keeps score, IDLE -> PLAY clears it
    bus.start = 1'b1; step(); bus.start = 1'b0;
    chk("rs_idle_state", 32'(bus.state),    0);
    chk("rs_idle_act",   32'(bus.active),   0);
    chk("rs_idle_go",    32'(bus.gameover), 0);
    chk("rs_idle_score", 32'(bus.score),    5);
    step();
    chk("rs_idle_hold",  32'(bus.state),    0);
    bus.start = 1'b1; step(); bus.start = 1'b0;
    chk("rs_play_state", 32'(bus.state),  1);
    chk("rs_play_score", 32'(bus.score),  0);
    chk("rs_play_act",   32'(bus.active), 1);

    // Bird fell off the column
    bus.bird_col = 8'h00; step(); bus.bird_col = 8'h10;
    chk("fall_state", 32'(bus.state),    2);
    chk("fall_go",    32'(bus.gameover), 1);

    // Collision in the same cycle as a tick
    go_idle_then_play();
    step(); step(); step();
    chk("ct_tick_on", 32'(bus.tick), 1);
    bus.pipe_col = 8'h10; step(); bus.pipe_col = 8'h00;
    chk("ct_state",    32'(bus.state), 2);
    chk("ct_tick_off", 32'(bus.tick),  0);

    // Saturation at 99
    go_idle_then_play();
    bus.pipe_pass = 1'b1;
    repeat (98) step();
    chk("score_98", 32'(bus.score), 98);
    step();
    chk("score_99", 32'(bus.score), 99);
    step();
    chk("score_sat", 32'(bus.score), 99);
    bus.pipe_pass = 1'b0;

    // Mid-game reset with score 3, start alongside reset ignored
    bus.bird_col = 8'h00; step(); bus.bird_col = 8'h10;
    go_idle_then_play();
    for (int k = 0; k < 3; k++) begin
      bus.pipe_pass = 1'b1; step(); bus.pipe_pass = 1'b0; step();
    end
    chk("mid_score3", 32'(bus.score), 3);
    reset = 1'b1; bus.start = 1'b1;
    step();
    chk("mid_rst_state", 32'(bus.state),  0);
    chk("mid_rst_score", 32'(bus.score),  0);
    chk("mid_rst_act",   32'(bus.active), 0);
    chk("mid_rst_tick",  32'(bus.tick),   0);
    step();
    chk("rst_start_ign", 32'(bus.state),  0);
    reset = 1'b0; bus.start = 1'b0;
    step();
    chk("post_rst_idle", 32'(bus.state),  0);
    chk("post_rst_act",  32'(bus.active), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
